// File: rtl/pcap_replay_sched.sv
// Packet-granular round-robin merge of four pcap replay streams into one AXI-Stream.
// Define PCAP_REPLAY_SCHED_CNT_EN to build the per-queue forwarded-packet counters.
`timescale 1ns/1ps

module pcap_replay_sched #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4
) (
    input  logic                              axis_aclk,
    input  logic                              reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s0_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s0_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s1_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s1_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s2_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s2_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s2_axis_tuser,
    input  logic                              s2_axis_tvalid,
    input  logic                              s2_axis_tlast,
    output logic                              s2_axis_tready,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s3_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s3_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s3_axis_tuser,
    input  logic                              s3_axis_tvalid,
    input  logic                              s3_axis_tlast,
    output logic                              s3_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    input  logic                              sched_en,
    input  logic [3:0]                        q_enable,
    input  logic                              cnt_clear,
    output logic                              busy,
    output logic [1:0]                        grant,
    output logic [31:0]                       pkt_cnt_0,
    output logic [31:0]                       pkt_cnt_1,
    output logic [31:0]                       pkt_cnt_2,
    output logic [31:0]                       pkt_cnt_3
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

    logic [DW-1:0]          s_tdata [NUM_QUEUES];
    logic [KW-1:0]          s_tkeep [NUM_QUEUES];
    logic [UW-1:0]          s_tuser [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]  s_tvalid;
    logic [NUM_QUEUES-1:0]  s_tlast;
    logic [NUM_QUEUES-1:0]  s_tready;
    logic [31:0]            pkt_cnt [NUM_QUEUES];

    state_t     state_reg;
    logic [1:0] grant_reg;
    logic [1:0] last_grant_reg;
    logic       busy_reg;

    logic       cand_found;
    logic [1:0] cand_idx;
    logic [1:0] search_idx;
    logic       last_beat;

    assign s_tdata[0] = s0_axis_tdata;  assign s_tkeep[0] = s0_axis_tkeep;  assign s_tuser[0] = s0_axis_tuser;
    assign s_tdata[1] = s1_axis_tdata;  assign s_tkeep[1] = s1_axis_tkeep;  assign s_tuser[1] = s1_axis_tuser;
    assign s_tdata[2] = s2_axis_tdata;  assign s_tkeep[2] = s2_axis_tkeep;  assign s_tuser[2] = s2_axis_tuser;
    assign s_tdata[3] = s3_axis_tdata;  assign s_tkeep[3] = s3_axis_tkeep;  assign s_tuser[3] = s3_axis_tuser;
    assign s_tvalid   = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign s_tlast    = {s3_axis_tlast,  s2_axis_tlast,  s1_axis_tlast,  s0_axis_tlast};

    assign s0_axis_tready = s_tready[0];
    assign s1_axis_tready = s_tready[1];
    assign s2_axis_tready = s_tready[2];
    assign s3_axis_tready = s_tready[3];

    assign pkt_cnt_0 = pkt_cnt[0];
    assign pkt_cnt_1 = pkt_cnt[1];
    assign pkt_cnt_2 = pkt_cnt[2];
    assign pkt_cnt_3 = pkt_cnt[3];

    assign busy  = busy_reg;
    assign grant = grant_reg;

    // Offset 4 wraps back to last_grant itself, so a lone active queue can be re-granted.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = last_grant_reg;
        search_idx = last_grant_reg;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            search_idx = last_grant_reg + 2'(k);
            if (!cand_found && q_enable[search_idx] && s_tvalid[search_idx]) begin
                cand_found = 1'b1;
                cand_idx   = search_idx;
            end
        end
    end

    assign last_beat = (state_reg == XFER) && s_tvalid[grant_reg] && s_tlast[grant_reg] && m_axis_tready;

    // Zero-latency passthrough of the granted queue; everything is forced to 0 outside XFER.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_tready      = '0;
        if (state_reg == XFER) begin
            m_axis_tdata        = s_tdata[grant_reg];
            m_axis_tkeep        = s_tkeep[grant_reg];
            m_axis_tuser        = s_tuser[grant_reg];
            m_axis_tvalid       = s_tvalid[grant_reg];
            m_axis_tlast        = s_tlast[grant_reg];
            s_tready[grant_reg] = m_axis_tready;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'd0;
            last_grant_reg <= 2'd3;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sched_en) state_reg <= ARB;
                end
                ARB: begin
                    if (!sched_en) begin
                        state_reg <= IDLE;
                    end else if (cand_found) begin
                        grant_reg <= cand_idx;
                        busy_reg  <= 1'b1;
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    // sched_en is only looked at here, so a packet always completes.
                    if (last_beat) begin
                        last_grant_reg <= grant_reg;
                        busy_reg       <= 1'b0;
                        state_reg      <= sched_en ? ARB : IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef PCAP_REPLAY_SCHED_CNT_EN
    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge axis_aclk) begin
                if (reset || cnt_clear) begin
                    cnt_reg <= 32'd0;
                end else if (last_beat && (grant_reg == 2'(gi))) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
            assign pkt_cnt[gi] = cnt_reg;
        end
    endgenerate
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_cnt
            assign pkt_cnt[gi] = 32'd0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_pcap_replay_sched.sv
// Scoreboard bench for pcap_replay_sched: per-queue source models, expected-beat queue, per-feature tasks.
`timescale 1ns/1ps

module tb_pcap_replay_sched;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
`ifdef PCAP_REPLAY_SCHED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [1:0] q; logic [DW-1:0] data; logic last; } exp_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] s_tdata [4];
    logic [KW-1:0] s_tkeep [4];
    logic [UW-1:0] s_tuser [4];
    logic [3:0]    s_tvalid;
    logic [3:0]    s_tlast;
    logic [3:0]    s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tlast, m_tready;
    logic          sched_en, cnt_clear, busy;
    logic [3:0]    q_enable;
    logic [1:0]    grant;
    logic [31:0]   pkt_cnt [4];

    beat_t src_q [4][$];
    exp_t  sb [$];
    int    hs_cyc [$];
    int    hs_cnt [4];
    int    cyc;
    int    n_checks;
    int    n_fail;

    pcap_replay_sched #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .NUM_QUEUES(4)) dut (
        .axis_aclk(clk), .reset(reset),
        .s0_axis_tdata(s_tdata[0]), .s0_axis_tkeep(s_tkeep[0]), .s0_axis_tuser(s_tuser[0]),
        .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tlast(s_tlast[0]), .s0_axis_tready(s_tready[0]),
        .s1_axis_tdata(s_tdata[1]), .s1_axis_tkeep(s_tkeep[1]), .s1_axis_tuser(s_tuser[1]),
        .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tlast(s_tlast[1]), .s1_axis_tready(s_tready[1]),
        .s2_axis_tdata(s_tdata[2]), .s2_axis_tkeep(s_tkeep[2]), .s2_axis_tuser(s_tuser[2]),
        .s2_axis_tvalid(s_tvalid[2]), .s2_axis_tlast(s_tlast[2]), .s2_axis_tready(s_tready[2]),
        .s3_axis_tdata(s_tdata[3]), .s3_axis_tkeep(s_tkeep[3]), .s3_axis_tuser(s_tuser[3]),
        .s3_axis_tvalid(s_tvalid[3]), .s3_axis_tlast(s_tlast[3]), .s3_axis_tready(s_tready[3]),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .sched_en(sched_en), .q_enable(q_enable), .cnt_clear(cnt_clear),
        .busy(busy), .grant(grant),
        .pkt_cnt_0(pkt_cnt[0]), .pkt_cnt_1(pkt_cnt[1]), .pkt_cnt_2(pkt_cnt[2]), .pkt_cnt_3(pkt_cnt[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mk(int q, int p, int b);
        logic [31:0] w;
        w = {8'(q), 8'(p), 8'(b), 8'hC3};
        return {8{w}};
    endfunction

    task automatic load_src(int q, int p, int nb);
        beat_t x;
        for (int b = 1; b <= nb; b++) begin
            x.data = mk(q, p, b);
            x.last = (b == nb);
            src_q[q].push_back(x);
        end
    endtask

    task automatic expect_beats(int q, int p, int b_from, int b_to, int nb);
        exp_t e;
        for (int b = b_from; b <= b_to; b++) begin
            e.q    = 2'(q);
            e.data = mk(q, p, b);
            e.last = (b == nb);
            sb.push_back(e);
        end
    endtask

    // Upstream sources plus output monitor: sample 1ns before the rising edge, re-drive 1ns after.
    initial begin
        logic [3:0] hs;
        logic [3:0] exp_rdy;
        logic       prev_last;
        exp_t       e;
        beat_t      h;
        prev_last = 1'b0;
        cyc = 0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int q = 0; q < 4; q++) begin
            s_tdata[q] = '0; s_tkeep[q] = '0; s_tuser[q] = '0;
        end
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            hs = '0;
            if (!reset) begin
                hs = s_tvalid & s_tready;
                exp_rdy = '0;
                if (busy) exp_rdy[grant] = m_tready;
                n_checks++;
                if (s_tready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL ready_routing: cyc %0d got %b expected %b", cyc, s_tready, exp_rdy);
                end
                n_checks++;
                if (!busy && (m_tvalid !== 1'b0 || m_tdata !== '0)) begin
                    n_fail++;
                    $display("FAIL idle_outputs: cyc %0d tvalid %b tdata_lo %h expected 0", cyc, m_tvalid, m_tdata[31:0]);
                end
                if (prev_last) begin
                    n_checks++;
                    if (m_tvalid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL arb_bubble: cyc %0d tvalid %b expected 0", cyc, m_tvalid);
                    end
                end
                if (m_tvalid && m_tready) begin
                    hs_cyc.push_back(cyc);
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: cyc %0d grant %0d tdata_lo %h expected no beat", cyc, grant, m_tdata[31:0]);
                    end else begin
                        e = sb.pop_front();
                        if (m_tdata !== e.data || m_tlast !== e.last || grant !== e.q ||
                            m_tkeep !== e.data[KW-1:0] || m_tuser !== ~e.data[UW-1:0]) begin
                            n_fail++;
                            $display("FAIL beat: cyc %0d got q%0d d=%h last=%b expected q%0d d=%h last=%b",
                                     cyc, grant, m_tdata[31:0], m_tlast, e.q, e.data[31:0], e.last);
                        end
                    end
                end
                prev_last = m_tvalid && m_tready && m_tlast;
            end else begin
                prev_last = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int q = 0; q < 4; q++) begin
                if (hs[q] && src_q[q].size() > 0) begin
                    src_q[q].delete(0);
                    hs_cnt[q]++;
                end
                if (src_q[q].size() > 0) begin
                    h = src_q[q][0];
                    s_tvalid[q] = 1'b1;
                    s_tlast[q]  = h.last;
                    s_tdata[q]  = h.data;
                    s_tkeep[q]  = h.data[KW-1:0];
                    s_tuser[q]  = ~h.data[UW-1:0];
                end else begin
                    s_tvalid[q] = 1'b0;
                    s_tlast[q]  = 1'b0;
                    s_tdata[q]  = '0;
                    s_tkeep[q]  = '0;
                    s_tuser[q]  = '0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sched_en = 1'b0; cnt_clear = 1'b0; m_tready = 1'b0; q_enable = 4'hF;
        for (int q = 0; q < 4; q++) begin
            src_q[q].delete();
            hs_cnt[q] = 0;
        end
        sb.delete();
        hs_cyc.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: tvalid %b tlast %b busy %b expected 0 0 0", m_tvalid, m_tlast, busy);
        end
        n_checks++;
        if (m_tdata !== '0 || m_tkeep !== '0 || m_tuser !== '0) begin
            n_fail++;
            $display("FAIL reset_data: tdata_lo %h tkeep %h expected 0", m_tdata[31:0], m_tkeep);
        end
        n_checks++;
        if (grant !== 2'd0 || s_tready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_grant: grant %0d ready %b expected 0 0000", grant, s_tready);
        end
        for (int q = 0; q < 4; q++) begin
            n_checks++;
            if (pkt_cnt[q] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_cnt%0d: got %0d expected 0", q, pkt_cnt[q]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m_tready = 1'b1;
        for (int p = 1; p <= 3; p++)
            for (int q = 0; q < 4; q++) begin
                load_src(q, p, 1);
                expect_beats(q, p, 1, 1, 1);
            end
        sched_en = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_timeout: %0d beats outstanding expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (hs_cyc.size() != 12 || hs_cyc[11] - hs_cyc[0] != 22) begin
            n_fail++;
            $display("FAIL rr_spacing: %0d beats span %0d cycles expected 12 beats span 22",
                     hs_cyc.size(), (hs_cyc.size() > 1) ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] : 0);
        end
        for (int q = 0; q < 4; q++) begin
            n_checks++;
            if (pkt_cnt[q] !== (CNT_EN ? 32'd3 : 32'd0)) begin
                n_fail++;
                $display("FAIL rr_cnt%0d: got %0d expected %0d", q, pkt_cnt[q], CNT_EN ? 3 : 0);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_tready = 1'b1;
        load_src(2, 1, 5);
        expect_beats(2, 1, 1, 5, 5);
        sched_en = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
            m_tready = ~m_tready;
        end
        n_checks++;
        if (sb.size() != 0 || hs_cnt[2] != 5) begin
            n_fail++;
            $display("FAIL bp_done: outstanding %0d consumed %0d expected 0 and 5", sb.size(), hs_cnt[2]);
        end
    endtask

    task automatic test_sched_stop();
        do_reset();
        m_tready = 1'b1;
        load_src(1, 1, 4);
        expect_beats(1, 1, 1, 4, 4);
        sched_en = 1'b1;
        for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
        load_src(0, 1, 1);
        load_src(2, 1, 1);
        load_src(3, 1, 1);
        @(negedge clk);
        sched_en = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0 || hs_cnt[1] != 4) begin
            n_fail++;
            $display("FAIL stop_tail: outstanding %0d q1 beats %0d expected 0 and 4", sb.size(), hs_cnt[1]);
        end
        begin
            int busy_cycles;
            busy_cycles = 0;
            for (int i = 0; i < 10; i++) begin
                if (busy !== 1'b0) busy_cycles++;
                @(negedge clk);
            end
            n_checks++;
            if (busy_cycles != 0 || hs_cnt[0] + hs_cnt[2] + hs_cnt[3] != 0) begin
                n_fail++;
                $display("FAIL stop_idle: busy cycles %0d other beats %0d expected 0 0",
                         busy_cycles, hs_cnt[0] + hs_cnt[2] + hs_cnt[3]);
            end
        end
    endtask

    task automatic test_enable_mask();
        do_reset();
        m_tready = 1'b1;
        q_enable = 4'b0101;
        for (int q = 0; q < 4; q++) begin
            load_src(q, 1, 1);
            load_src(q, 2, 1);
        end
        expect_beats(0, 1, 1, 1, 1);
        expect_beats(2, 1, 1, 1, 1);
        expect_beats(0, 2, 1, 1, 1);
        expect_beats(2, 2, 1, 1, 1);
        sched_en = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_checks++;
        if (sb.size() != 0 || hs_cnt[1] != 0 || hs_cnt[3] != 0) begin
            n_fail++;
            $display("FAIL mask: outstanding %0d q1 %0d q3 %0d expected 0 0 0", sb.size(), hs_cnt[1], hs_cnt[3]);
        end
    endtask

    task automatic test_cnt_clear();
        do_reset();
        m_tready = 1'b1;
        for (int p = 1; p <= 8; p++) begin
            load_src(0, p, 1);
            expect_beats(0, p, 1, 1, 1);
        end
        sched_en = 1'b1;
        for (int i = 0; i < 100 && !(hs_cnt[0] == 7 && busy === 1'b1); i++) @(negedge clk);
        n_checks++;
        if (pkt_cnt[0] !== (CNT_EN ? 32'd7 : 32'd0) || hs_cnt[0] != 7) begin
            n_fail++;
            $display("FAIL cnt_pre: got %0d (beats %0d) expected %0d", pkt_cnt[0], hs_cnt[0], CNT_EN ? 7 : 0);
        end
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        n_checks++;
        if (pkt_cnt[0] !== 32'd0 || hs_cnt[0] != 8) begin
            n_fail++;
            $display("FAIL cnt_clear: got %0d (beats %0d) expected 0 after 8 beats", pkt_cnt[0], hs_cnt[0]);
        end
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        m_tready = 1'b1;
        load_src(2, 1, 8);
        expect_beats(2, 1, 1, 2, 8);
        sched_en = 1'b1;
        for (int i = 0; i < 50 && !(hs_cnt[2] == 2 && busy === 1'b1); i++) @(negedge clk);
        m_tready = 1'b0;
        reset = 1'b1;
        sched_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || grant !== 2'd0 || s_tready !== 4'b0000 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL midreset: tvalid %b busy %b grant %0d ready %b expected 0 0 0 0000",
                     m_tvalid, busy, grant, s_tready);
        end
        reset = 1'b0;
        m_tready = 1'b1;
        load_src(0, 1, 1);
        expect_beats(0, 1, 1, 1, 1);
        expect_beats(2, 1, 3, 8, 8);
        @(negedge clk);
        sched_en = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0 || hs_cnt[2] != 8) begin
            n_fail++;
            $display("FAIL resume: outstanding %0d q2 beats %0d expected 0 and 8", sb.size(), hs_cnt[2]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        sched_en = 1'b0;
        cnt_clear = 1'b0;
        m_tready = 1'b0;
        q_enable = 4'hF;
        for (int q = 0; q < 4; q++) hs_cnt[q] = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sched_stop();
        test_enable_mask();
        test_cnt_clear();
        test_reset_midpacket();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcap_replay_sched.md
# pcap_replay_sched

Packet-granular round-robin scheduler that merges the four per-queue replay streams read back from external pcap memory into the single replay AXI-Stream toward the output ports. It sits between the four memory readback channels and the replay timing/egress stage. It is the sequencing counterpart of the store path that fills those queues from host DMA. It grants one queue at a time for a whole packet, honours a per-queue enable mask and a global run control, and optionally keeps per-queue packet counters.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width of all streams; tkeep is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width of all streams.
- NUM_QUEUES, 4, number of replay queues; fixed at 4 by the port list.

Ports:
- axis_aclk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- sN_axis_tdata/tkeep/tuser/tvalid/tlast  in  per width  replay stream from queue N, N = 0..3.
- sN_axis_tready  out  1  ready to queue N.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per width  merged replay stream.
- m_axis_tready  in  1  downstream ready.
- sched_en  in  1  run control; 1 allows new grants.
- q_enable  in  4  per-queue enable mask; bit N gates queue N.
- cnt_clear  in  1  clears packet counters (only when the macro is compiled in).
- busy  out  1  high while a packet is granted (state XFER).
- grant  out  2  index of the queue currently or last granted.
- pkt_cnt_0..3  out  32  per-queue forwarded-packet counters (only when the macro is compiled in).

## Operation
- State machine states:
  - IDLE: all sN_axis_tready = 0 and m_axis_tvalid = 0. When sched_en = 1, go to ARB.
  - ARB: search queues in order (last_grant+1) mod 4, then +2, +3, +4. Pick the first N where q_enable[N] & sN_axis_tvalid. If found, grant <= N and go to XFER. If none is found, stay in ARB. If sched_en = 0, go to IDLE; this takes priority over a found candidate.
  - XFER: m_axis_* = sN_axis_* of the granted queue, passed through combinationally. s[grant]_axis_tready = m_axis_tready; all other readies are 0. On a beat with tvalid & tready & tlast: last_grant <= grant, increment pkt_cnt[grant], then go to ARB if sched_en = 1, else go to IDLE.
- Packets are never truncated:
  - sched_en falling mid-packet takes effect only after the tlast beat.
  - A q_enable change mid-packet is ignored until the next ARB.
- Round-robin fairness: a queue that is continuously valid and enabled is granted at least once every 4 packets.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0. cnt_clear has priority over a same-cycle increment; the result is 0.
- grant holds its value in IDLE and ARB and only changes on entry to XFER.

## Timing
- Reset values:
  - state = IDLE, grant = 0, last_grant = 3 (so the first search starts at queue 0), busy = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata/tkeep/tuser = 0.
  - All sN_axis_tready = 0; all pkt_cnt = 0.
- Data latency in XFER is 0 cycles (combinational passthrough); no registering of tdata.
- Arbitration costs exactly one cycle: the cycle after a tlast beat is ARB with m_axis_tvalid = 0, and the next packet's first beat can appear the cycle after that.
- In IDLE and ARB, m_axis_* data outputs are driven to 0.
- Reset asserted mid-packet: the next cycle is IDLE with all outputs at reset values. The partial packet is abandoned, and upstream resumes mid-packet data with no resynchronisation by this block.
- Simultaneous tvalid on all queues: the round-robin order strictly determines the grant.

## Configuration
- PCAP_REPLAY_SCHED_CNT_EN:
  - Defined: the pkt_cnt_0..3 ports and counters exist, and cnt_clear is functional.
  - Undefined: the counter logic is not built, pkt_cnt_0..3 are tied to 0, and cnt_clear is ignored. Scheduling behaviour is identical in both cases.

## Test plan
- Reset, sched_en = 1, q_enable = 4'hF, all 4 queues each holding 3 one-beat packets, m_axis_tready = 1 -> grant sequence 0,1,2,3,0,1,2,3,0,1,2,3. Each packet is followed by one ARB bubble. pkt_cnt_N = 3 for all N.
- Only queue 2 is valid with a 5-beat packet and m_axis_tready toggled 1,0,1,0,… -> all 5 beats are forwarded in order with tdata unchanged. tlast appears only on beat 5. s2_axis_tready mirrors m_axis_tready, and s0/s1/s3 tready stay 0.
- sched_en dropped on beat 2 of a 4-beat packet from queue 1 -> beats 3 and 4 are still forwarded. IDLE is entered the cycle after tlast, and no further grants occur while other queues are valid.
- q_enable = 4'b0101 with all queues valid -> grants alternate 0,2,0,2. Queues 1 and 3 see tready = 0 throughout.
- cnt_clear asserted in the same cycle as the tlast beat of queue 0 (with pkt_cnt_0 = 7) -> pkt_cnt_0 = 0 next cycle. With the macro undefined, all pkt_cnt stay 0.
- Reset pulsed during beat 3 of an 8-beat packet -> the next cycle has m_axis_tvalid = 0, busy = 0, grant = 0, and all readies 0. After release, the first grant goes to queue 0.
